// File: rtl/struct_s.sv
// Shared type package for the packet admission gate and its neighbours.
package struct_s;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } gate_state_t;

  localparam int CNT_WIDTH = 32;

endpackage

// File: rtl/pkt_drop_gate_avlstrm_if.sv
// Avalon-ST beat bundle; rx is the receiving side, tx the sending side (which also sees almost_full).
interface avl_stream_if #(
  parameter int DATA_WIDTH  = 512,
  parameter int EMPTY_WIDTH = 6
);

  logic [DATA_WIDTH-1:0]  data;
  logic                   sop;
  logic                   eop;
  logic [EMPTY_WIDTH-1:0] empty;
  logic                   valid;
  logic                   ready;
  logic                   almost_full;

  modport tx (
    output data, sop, eop, empty, valid,
    input  ready, almost_full
  );

  modport rx (
    input  data, sop, eop, empty, valid,
    output ready
  );

endinterface

// File: rtl/avlstrm_pipe_reg.sv
// One-entry ready/valid register stage for Avalon-ST beats; holds its contents while stalled.
module avlstrm_pipe_reg #(
  parameter int DATA_WIDTH  = 512,
  parameter int EMPTY_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   up_valid,
  output logic                   up_ready,
  input  logic [DATA_WIDTH-1:0]  up_data,
  input  logic                   up_sop,
  input  logic                   up_eop,
  input  logic [EMPTY_WIDTH-1:0] up_empty,
  output logic                   dn_valid,
  input  logic                   dn_ready,
  output logic [DATA_WIDTH-1:0]  dn_data,
  output logic                   dn_sop,
  output logic                   dn_eop,
  output logic [EMPTY_WIDTH-1:0] dn_empty
);

  assign up_ready = ~dn_valid | dn_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
      dn_sop   <= 1'b0;
      dn_eop   <= 1'b0;
      dn_empty <= '0;
    end else if (up_valid && up_ready) begin
      dn_valid <= 1'b1;
      dn_data  <= up_data;
      dn_sop   <= up_sop;
      dn_eop   <= up_eop;
      dn_empty <= up_empty;
    end else if (dn_ready) begin
      dn_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pkt_drop_gate_avlstrm.sv
// Whole-packet admission gate in front of the packet FIFO: admits or discards each packet at its sop.
// Statistics counters exist only when PKT_GATE_STATS_EN is defined; otherwise they read as 0.
module pkt_drop_gate_avlstrm
  import struct_s::*;
#(
  parameter int DATA_WIDTH  = 512,
  parameter int EMPTY_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  avl_stream_if.rx             in,
  avl_stream_if.tx             out,
  output logic [CNT_WIDTH-1:0] pkt_cnt,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  gate_state_t state, state_nxt;
  logic        accept;
  logic        fwd;
  logic        pipe_ready;
  logic        inc_pkt;
  logic        inc_drop;
  logic        inc_err;

  // A dropping packet is swallowed at full rate regardless of downstream backpressure.
  assign in.ready = (state == DROP) ? 1'b1 : pipe_ready;
  assign accept   = in.valid & in.ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fwd       = 1'b0;
    inc_pkt   = 1'b0;
    inc_drop  = 1'b0;
    inc_err   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!in.sop) begin
            inc_err = 1'b1;
          end else if (!out.almost_full) begin
            fwd = 1'b1;
            if (in.eop) inc_pkt   = 1'b1;
            else        state_nxt = PASS;
          end else begin
            inc_drop = 1'b1;
            if (!in.eop) state_nxt = DROP;
          end
        end
      end
      PASS: begin
        if (accept) begin
          if (in.sop) begin
            inc_err   = 1'b1;
            state_nxt = in.eop ? IDLE : DROP;
          end else begin
            fwd = 1'b1;
            if (in.eop) begin
              inc_pkt   = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
      end
      DROP: begin
        if (accept) begin
          if (in.sop) inc_err   = 1'b1;
          if (in.eop) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  avlstrm_pipe_reg #(
    .DATA_WIDTH  (DATA_WIDTH),
    .EMPTY_WIDTH (EMPTY_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .up_valid (fwd),
    .up_ready (pipe_ready),
    .up_data  (in.data),
    .up_sop   (in.sop),
    .up_eop   (in.eop),
    .up_empty (in.empty),
    .dn_valid (out.valid),
    .dn_ready (out.ready),
    .dn_data  (out.data),
    .dn_sop   (out.sop),
    .dn_eop   (out.eop),
    .dn_empty (out.empty)
  );

`ifdef PKT_GATE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (inc_pkt)  pkt_cnt  <= pkt_cnt  + 32'd1;
      if (inc_drop) drop_cnt <= drop_cnt + 32'd1;
      if (inc_err)  err_cnt  <= err_cnt  + 32'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = ^{inc_pkt, inc_drop, inc_err};
  assign pkt_cnt      = '0;
  assign drop_cnt     = '0;
  assign err_cnt      = '0;
`endif

endmodule
